// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: frame marker,
// FSM state encoding, checksum type and timeout arithmetic.
package uart_cmd_pkg;

    // Default start-of-frame marker
    localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;

    // Running checksum is a plain byte-wide XOR
    localparam int CHK_W = 8;
    typedef logic [CHK_W-1:0] chk_t;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CHK     = 3'd4;
    localparam logic [2:0] ST_HOLD    = 3'd5;

    // Inter-byte timeout in clock cycles: to_bytes byte times of
    // 10 bit periods each.
    function automatic int calc_to_cyc(
        input int clk_freq,
        input int baud,
        input int to_bytes
    );
        return to_bytes * 10 * (clk_freq / baud);
    endfunction

    // States in which a frame is partially received and the
    // inter-byte timer is running.
    function automatic logic in_frame_state(input logic [2:0] s);
        return (s == ST_CMD) || (s == ST_LEN) ||
               (s == ST_PAYLOAD) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte timeout counter for the command parser.
// Ports: clk, rst_n, clr (synchronous clear, wins), en (count),
// expired (combinational, high while count sits at TO_CYC-1).
module cmd_timeout_timer #(
    parameter  int TO_CYC = 17360,
    localparam int W      = (TO_CYC > 1) ? $clog2(TO_CYC) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(TO_CYC - 1);

    logic [W-1:0] cnt;

    // Expiry is only reported on a cycle with no clear, so a byte
    // arriving exactly at the limit still counts as in time.
    assign expired = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART frame decoder: [SOF][CMD][LEN][PAYLOAD x LEN][CHK] -> one
// validated command at a time on a valid/ready handshake.
// Ports: clk, rst_n; rx_data/rx_done/framing_err from the byte
// receiver; cmd_valid/cmd_ready/cmd_op/cmd_len to the consumer;
// rd_addr/rd_data combinational payload read port; err_chk,
// err_len, err_frame, err_timeout, err_overrun 1-cycle pulses;
// busy high whenever the FSM is not idle.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter  int         CLK_FREQ = 50000000,
    parameter  int         BAUD     = 115200,
    parameter  int         MAX_LEN  = 16,
    parameter  logic [7:0] SOF_BYTE = SOF_BYTE_DEF,
    parameter  int         TO_BYTES = 4,
    localparam int         AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          framing_err,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [7:0]    cmd_op,
    output logic [7:0]    cmd_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_chk,
    output logic          err_len,
    output logic          err_frame,
    output logic          err_timeout,
    output logic          err_overrun,
    output logic          busy
);

    localparam int TO_CYC = calc_to_cyc(CLK_FREQ, BAUD, TO_BYTES);

    logic [2:0] state;
    chk_t       chk;
    logic [7:0] idx;
    logic [7:0] pbuf [MAX_LEN];

    logic in_frame;
    logic hs;
    logic buf_we;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;

    assign in_frame = in_frame_state(state);
    assign hs       = (state == ST_HOLD) && cmd_valid && cmd_ready;
    assign busy     = (state != ST_IDLE);
    assign buf_we   = (state == ST_PAYLOAD) && rx_done && !framing_err;

    // Timer only runs while a frame is partially received
    assign tmr_clr = rx_done || !in_frame;
    assign tmr_en  = in_frame;

    cmd_timeout_timer #(
        .TO_CYC (TO_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Entries past the current length read as zero so stale bytes
    // of an older, longer command never leak out.
    always_comb begin
        rd_data = 8'h00;
        if (9'(rd_addr) < 9'(cmd_len)) begin
            rd_data = pbuf[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                pbuf[i] <= 8'h00;
            end
        end else if (buf_we) begin
            pbuf[idx[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            chk         <= '0;
            idx         <= '0;
            cmd_valid   <= 1'b0;
            cmd_op      <= '0;
            cmd_len     <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;

            if (hs) begin
                // Command consumed; a byte in this same cycle is
                // treated as the first byte seen from idle.
                cmd_valid <= 1'b0;
                state     <= ST_IDLE;
                if (framing_err) begin
                    err_frame <= 1'b1;
                end else if (rx_done && (rx_data == SOF_BYTE)) begin
                    state <= ST_CMD;
                    chk   <= '0;
                end
            end else if (framing_err) begin
                // A held command survives a line error
                err_frame <= 1'b1;
                if (state != ST_HOLD) begin
                    state <= ST_IDLE;
                end
            end else if (rx_done) begin
                unique case (1'b1)
                    (state == ST_IDLE): begin
                        if (rx_data == SOF_BYTE) begin
                            state <= ST_CMD;
                            chk   <= '0;
                        end
                    end
                    (state == ST_CMD): begin
                        cmd_op <= rx_data;
                        chk    <= chk ^ rx_data;
                        state  <= ST_LEN;
                    end
                    (state == ST_LEN): begin
                        if (rx_data > 8'(MAX_LEN)) begin
                            err_len <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            cmd_len <= rx_data;
                            chk     <= chk ^ rx_data;
                            idx     <= '0;
                            state   <= (rx_data == 8'h00) ?
                                       ST_CHK : ST_PAYLOAD;
                        end
                    end
                    (state == ST_PAYLOAD): begin
                        chk <= chk ^ rx_data;
                        idx <= idx + 8'd1;
                        if (idx == (cmd_len - 8'd1)) begin
                            state <= ST_CHK;
                        end
                    end
                    (state == ST_CHK): begin
                        if (rx_data == chk) begin
                            cmd_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                    (state == ST_HOLD): begin
                        // Consumer still busy: byte is dropped
                        err_overrun <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end else if (tmr_expired) begin
                err_timeout <= 1'b1;
                state       <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed testbench for uart_cmd_parser: table of frames plus
// hand-written overrun, timeout, framing and reset sequences.
module tb_uart_cmd_parser;

    localparam int MAX_LEN = 16;
    localparam int AW      = 4;
    localparam int TO_CYC  = 400;
    localparam int NV      = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_done = 1'b0;
    logic          framing_err = 1'b0;
    logic          cmd_valid;
    logic          cmd_ready = 1'b1;
    logic [7:0]    cmd_op;
    logic [7:0]    cmd_len;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          err_chk;
    logic          err_len;
    logic          err_frame;
    logic          err_timeout;
    logic          err_overrun;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int n_chk = 0;
    int n_len = 0;
    int n_frm = 0;
    int n_to = 0;
    int n_ovr = 0;

    typedef logic [0:19][7:0] frame_t;

    typedef struct {
        frame_t     f;
        int         n;
        bit         ev;
        logic [7:0] op;
        logic [7:0] len;
        logic [7:0] d0;
        logic [7:0] d1;
        int         e_chk;
        int         e_len;
    } vec_t;

    vec_t vt [NV];

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .CLK_FREQ (1000),
        .BAUD     (100),
        .MAX_LEN  (MAX_LEN),
        .SOF_BYTE (8'hA5),
        .TO_BYTES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .framing_err (framing_err),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_frame   (err_frame),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    always @(negedge clk) begin
        if (err_chk)     n_chk++;
        if (err_len)     n_len++;
        if (err_frame)   n_frm++;
        if (err_timeout) n_to++;
        if (err_overrun) n_ovr++;
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic send_frame(input frame_t f, input int n);
        for (int k = 0; k < n; k++) begin
            send_byte(f[20-n+k]);
        end
    endtask

    task automatic pulse_frame_err();
        @(negedge clk);
        framing_err = 1'b1;
        @(negedge clk);
        framing_err = 1'b0;
    endtask

    task automatic read_at(input logic [AW-1:0] a,
                           output logic [7:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int         b_chk;
        int         b_len;
        int         b_oth;
        int         b_to;
        bit         seen;
        logic [7:0] d;

        vt[0] = '{160'({8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21}),
                  6, 1'b1, 8'h10, 8'h02, 8'h11, 8'h22, 0, 0};
        vt[1] = '{160'({8'hA5, 8'h05, 8'h00, 8'h05}),
                  4, 1'b1, 8'h05, 8'h00, 8'h00, 8'h00, 0, 0};
        vt[2] = '{160'({8'hA5, 8'h05, 8'h00, 8'h06}),
                  4, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0};
        vt[3] = '{160'({8'hA5, 8'h01, 8'h11}),
                  3, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1};
        vt[4] = '{160'({8'hA5, 8'h01, 8'h00, 8'h01}),
                  4, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0};
        vt[5] = '{160'({8'h33, 8'hA5, 8'h07, 8'h01, 8'h5A, 8'h5C}),
                  6, 1'b1, 8'h07, 8'h01, 8'h5A, 8'h00, 0, 0};
        vt[6] = '{{8'hA5, 8'h20, 8'h10,
                   8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86,
                   8'h87, 8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D,
                   8'h8E, 8'h8F, 8'h30},
                  20, 1'b1, 8'h20, 8'h10, 8'h80, 8'h81, 0, 0};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(cmd_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_op", 32'(cmd_op), 0);
        check("rst_len", 32'(cmd_len), 0);
        check("rst_rd", 32'(rd_data), 0);
        check("rst_errs", 32'({err_chk, err_len, err_frame,
                               err_timeout, err_overrun}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // Table of frames, consumer always ready
        cmd_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            b_chk = n_chk;
            b_len = n_len;
            b_oth = n_frm + n_to + n_ovr;
            send_frame(vt[i].f, vt[i].n);
            #1;
            check($sformatf("v%0d_valid", i), 32'(cmd_valid),
                  32'(vt[i].ev));
            if (vt[i].ev) begin
                check($sformatf("v%0d_op", i), 32'(cmd_op),
                      32'(vt[i].op));
                check($sformatf("v%0d_len", i), 32'(cmd_len),
                      32'(vt[i].len));
                read_at(4'd0, d);
                check($sformatf("v%0d_d0", i), 32'(d), 32'(vt[i].d0));
                read_at(4'd1, d);
                check($sformatf("v%0d_d1", i), 32'(d), 32'(vt[i].d1));
            end
            repeat (3) @(negedge clk);
            #1;
            check($sformatf("v%0d_echk", i), 32'(n_chk - b_chk),
                  32'(vt[i].e_chk));
            check($sformatf("v%0d_elen", i), 32'(n_len - b_len),
                  32'(vt[i].e_len));
            check($sformatf("v%0d_eoth", i),
                  32'(n_frm + n_to + n_ovr - b_oth), 0);
            check($sformatf("v%0d_idle", i), 32'(cmd_valid), 0);
            check($sformatf("v%0d_busy", i), 32'(busy), 0);
        end

        // Timeout: not before the limit, then exactly once
        b_to = n_to;
        send_byte(8'hA5);
        send_byte(8'h10);
        repeat (TO_CYC - 10) @(negedge clk);
        #1;
        check("to_early_cnt", 32'(n_to - b_to), 0);
        check("to_early_busy", 32'(busy), 1);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (n_to != b_to) seen = 1'b1;
        end
        check("to_fired", 32'(seen), 1);
        check("to_busy", 32'(busy), 0);
        send_frame(vt[5].f, vt[5].n);
        #1;
        check("to_after_valid", 32'(cmd_valid), 1);
        check("to_after_op", 32'(cmd_op), 32'h07);
        repeat (3) @(negedge clk);

        // Overrun while holding, framing error while holding
        cmd_ready = 1'b0;
        send_frame(vt[0].f, vt[0].n);
        #1;
        check("ovr_valid", 32'(cmd_valid), 1);
        b_oth = n_ovr;
        b_chk = n_frm;
        send_byte(8'h33);
        send_byte(8'h44);
        pulse_frame_err();
        @(negedge clk);
        #1;
        check("ovr_cnt", 32'(n_ovr - b_oth), 2);
        check("hold_frm_cnt", 32'(n_frm - b_chk), 1);
        check("ovr_still_valid", 32'(cmd_valid), 1);
        check("ovr_op", 32'(cmd_op), 32'h10);
        check("ovr_len", 32'(cmd_len), 32'h02);
        read_at(4'd1, d);
        check("ovr_d1", 32'(d), 32'h22);
        // Handshake in the same cycle as the next SOF
        @(negedge clk);
        cmd_ready = 1'b1;
        rx_data = 8'hA5;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
        #1;
        check("hs_valid_drop", 32'(cmd_valid), 0);
        check("hs_new_busy", 32'(busy), 1);
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h05);
        #1;
        check("hs_new_valid", 32'(cmd_valid), 1);
        check("hs_new_op", 32'(cmd_op), 32'h05);
        repeat (3) @(negedge clk);

        // Framing error mid-payload aborts the frame
        b_chk = n_frm;
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h02);
        send_byte(8'h11);
        pulse_frame_err();
        @(negedge clk);
        #1;
        check("frm_cnt", 32'(n_frm - b_chk), 1);
        check("frm_busy", 32'(busy), 0);
        check("frm_valid", 32'(cmd_valid), 0);

        // Reset while a command is held
        cmd_ready = 1'b0;
        send_frame(vt[0].f, vt[0].n);
        #1;
        check("rst2_pre_valid", 32'(cmd_valid), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst2_valid", 32'(cmd_valid), 0);
        check("rst2_busy", 32'(busy), 0);
        check("rst2_op", 32'(cmd_op), 0);
        check("rst2_len", 32'(cmd_len), 0);
        read_at(4'd0, d);
        check("rst2_rd", 32'(d), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
